// File: rtl/fb_pkg.sv
// Shared constants and state type for the double-buffered frame store controller.
package fb_pkg;

    localparam int unsigned SCREEN_WIDTH  = 320;
    localparam int unsigned SCREEN_HEIGHT = 180;
    localparam int unsigned FB_DEPTH      = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int unsigned PIXEL_WIDTH   = 16;
    localparam int unsigned COUNT_WIDTH   = 16;
    localparam int unsigned ADDR_WIDTH    = 16;

    typedef enum logic [1:0] {FILL, RAY_DONE, SWAP} fb_state_t;

endpackage

// File: rtl/fb_swap_controller_if.sv
// Producer-side valid/ready pixel stream into the frame-buffer swap controller.
interface fb_swap_controller_if
    import fb_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH_P = PIXEL_WIDTH
);
    logic                   ray_valid_in;
    logic                   ray_ready_out;
    logic [ADDR_WIDTH-1:0]  ray_address_in;
    logic [PIXEL_WIDTH_P-1:0] ray_pixel_in;
    logic                   ray_last_pixel_in;

    modport master (
        output ray_valid_in,
        output ray_address_in,
        output ray_pixel_in,
        output ray_last_pixel_in,
        input  ray_ready_out
    );

    modport slave (
        input  ray_valid_in,
        input  ray_address_in,
        input  ray_pixel_in,
        input  ray_last_pixel_in,
        output ray_ready_out
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             pixel_clk_in,
    input  logic             rst_in,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);
    logic [WIDTH-1:0] r_value;

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + WIDTH'(1);
        end
    end

    assign value = r_value;
endmodule

// File: rtl/fb_swap_controller.sv
// Steers producer pixels into the back buffer and swaps buffers once a full frame is
// written and the display has just shown its last active pixel.
module fb_swap_controller
    import fb_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH_P  = SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT_P = SCREEN_HEIGHT,
    parameter int unsigned PIXEL_WIDTH_P   = PIXEL_WIDTH,
    parameter int unsigned COUNT_WIDTH_P   = COUNT_WIDTH
) (
    input  logic                     pixel_clk_in,
    input  logic                     rst_in,
    fb_swap_controller_if.slave      ray_bus,
    input  logic                     video_last_pixel_in,
    output logic [ADDR_WIDTH-1:0]    wr_addr_out,
    output logic [PIXEL_WIDTH_P-1:0] wr_data_out,
    output logic                     wr_en_fb1_out,
    output logic                     wr_en_fb2_out,
    output logic                     front_sel_out,
    output logic                     swap_out,
    output logic                     frame_start_out,
    output logic [COUNT_WIDTH_P-1:0] repeat_count_out,
    output logic [COUNT_WIDTH_P-1:0] oob_count_out
);
    localparam logic [ADDR_WIDTH-1:0] DepthLimit = ADDR_WIDTH'(SCREEN_WIDTH_P * SCREEN_HEIGHT_P);

    fb_state_t               r_state, w_state_next;
    logic                    r_ready;
    logic                    r_front;
    logic                    r_swap;
    logic                    r_en_fb1, r_en_fb2;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [PIXEL_WIDTH_P-1:0] r_data;
    logic                    w_accept, w_in_range, w_repeat_inc, w_oob_inc;

    assign w_accept   = ray_bus.ray_valid_in & r_ready;
    assign w_in_range = ray_bus.ray_address_in < DepthLimit;
    assign w_oob_inc  = w_accept & ~w_in_range;

    always_comb begin
        w_state_next = r_state;
        w_repeat_inc = 1'b0;
        unique case (r_state)
            FILL: begin
                if (w_accept && ray_bus.ray_last_pixel_in) begin
                    w_state_next = video_last_pixel_in ? SWAP : RAY_DONE;
                end else if (video_last_pixel_in) begin
                    w_repeat_inc = 1'b1;
                end
            end
            RAY_DONE: begin
                if (video_last_pixel_in) begin
                    w_state_next = SWAP;
                end
            end
            SWAP: begin
                w_state_next = FILL;
                w_repeat_inc = video_last_pixel_in;
            end
            default: w_state_next = FILL;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= FILL;
            r_ready  <= 1'b0;
            r_front  <= 1'b0;
            r_swap   <= 1'b0;
            r_en_fb1 <= 1'b0;
            r_en_fb2 <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_ready  <= (w_state_next == FILL);
            r_swap   <= (w_state_next == SWAP);
            // Enables use the pre-swap select, so a frame's final write lands in the back buffer.
            r_en_fb1 <= w_accept & w_in_range & ~r_front;
            r_en_fb2 <= w_accept & w_in_range & r_front;
            if (r_state == SWAP) begin
                r_front <= ~r_front;
            end
            if (w_accept && w_in_range) begin
                r_addr <= ray_bus.ray_address_in;
                r_data <= ray_bus.ray_pixel_in;
            end
        end
    end

    sat_counter #(.WIDTH(COUNT_WIDTH_P)) u_repeat_cnt (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .inc          (w_repeat_inc),
        .value        (repeat_count_out)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH_P)) u_oob_cnt (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .inc          (w_oob_inc),
        .value        (oob_count_out)
    );

    assign ray_bus.ray_ready_out = r_ready;
    assign wr_addr_out           = r_addr;
    assign wr_data_out           = r_data;
    assign wr_en_fb1_out         = r_en_fb1;
    assign wr_en_fb2_out         = r_en_fb2;
    assign front_sel_out         = r_front;
    assign swap_out              = r_swap;
    assign frame_start_out       = r_swap;
endmodule
